// File: rtl/soc_data_memory_arbiter_pkg.sv
// Shared types, default widths and the round-robin pick function for the data memory arbiter.
package soc_mem_arb_pkg;

    localparam int unsigned DEF_NUM_MASTERS  = 2;
    localparam int unsigned DEF_ADDR_W       = 15;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_BE_W         = 4;
    localparam int unsigned DEF_LOCK_TIMEOUT = 16;
    localparam int unsigned MAX_MASTERS      = 8;
    localparam int unsigned MAX_IDX_W        = 3;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // One-hot grant: first requester scanning from last+1, wrapping modulo n.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [MAX_IDX_W-1:0]   last,
        input int unsigned            n
    );
        logic [MAX_MASTERS-1:0] grant;
        logic [MAX_IDX_W-1:0]   idx;
        grant = '0;
        for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
            idx = MAX_IDX_W'((32'(last) + k) % n);
            if (k <= n && grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/soc_data_memory_arbiter_if.sv
// Bus bundle: per-master Avalon-MM data ports plus the memory s1 side.
interface soc_data_memory_arbiter_if
    import soc_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned BE_W        = DEF_BE_W
);
    logic [NUM_MASTERS*ADDR_W-1:0] m_address;
    logic [NUM_MASTERS*BE_W-1:0]   m_byteenable;
    logic [NUM_MASTERS-1:0]        m_read;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
    logic [NUM_MASTERS-1:0]        m_lock;
    logic [NUM_MASTERS-1:0]        m_waitrequest;
    logic [NUM_MASTERS*DATA_W-1:0] m_readdata;
    logic [NUM_MASTERS-1:0]        m_readdatavalid;
    logic [ADDR_W-1:0]             mem_address;
    logic [BE_W-1:0]               mem_byteenable;
    logic                          mem_chipselect;
    logic                          mem_write;
    logic [DATA_W-1:0]             mem_writedata;
    logic                          mem_clken;
    logic [DATA_W-1:0]             mem_readdata;

    // Requesting side: the CPU masters and the memory read-data return.
    modport master (
        output m_address, m_byteenable, m_read, m_write, m_writedata, m_lock, mem_readdata,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );

    // Arbiter side.
    modport slave (
        input  m_address, m_byteenable, m_read, m_write, m_writedata, m_lock, mem_readdata,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/soc_rr_arbiter.sv
// Round-robin arbiter with registered last-grant pointer and an eligibility mask.
module soc_rr_arbiter
    import soc_mem_arb_pkg::*;
#(
    parameter  int unsigned N     = DEF_NUM_MASTERS,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);
    logic [IDX_W-1:0] last_grant;

    // Pick among eligible requesters and encode the winner's index.
    always_comb begin
        grant     = N'(rr_pick(MAX_MASTERS'(req & enable), MAX_IDX_W'(last_grant), N));
        grant_idx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
        grant_valid = |grant;
    end

    // Pointer reset to the top index so master 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= IDX_W'(N - 1);
        end else if (grant_valid) begin
            last_grant <= grant_idx;
        end
    end
endmodule

// File: rtl/soc_data_memory_arbiter.sv
// Shares the single-port data memory between CPU data masters: mux, read return, lock and lock timeout.
module soc_data_memory_arbiter
    import soc_mem_arb_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS  = DEF_NUM_MASTERS,
    parameter  int unsigned ADDR_W       = DEF_ADDR_W,
    parameter  int unsigned DATA_W       = DEF_DATA_W,
    parameter  int unsigned BE_W         = DEF_BE_W,
    parameter  int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    localparam int unsigned IDX_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int unsigned CNT_W        = $clog2(LOCK_TIMEOUT)
) (
    input  logic                     clk,
    input  logic                     reset,
    soc_data_memory_arbiter_if.slave bus,
    output logic                     lock_timeout
);
    logic [NUM_MASTERS-1:0]             req;
    logic [NUM_MASTERS-1:0]             enable;
    logic [NUM_MASTERS-1:0]             grant;
    logic [IDX_W-1:0]                   grant_idx;
    logic                               arb_valid;
    logic                               granted;
    logic                               lock_bit;
    logic                               accept_read;
    logic                               owner_req;
    lock_state_e                        lock_state;
    logic [IDX_W-1:0]                   owner;
    logic [CNT_W-1:0]                   idle_cnt;
    logic                               rd_valid;
    logic [IDX_W-1:0]                   rd_id;
    logic [NUM_MASTERS-1:0][DATA_W-1:0] rd_hold;

    soc_rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .enable      (enable),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (arb_valid)
    );

    // Requests and the lock mask: only the owner is eligible while the lock is held.
    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            req[i]    = bus.m_read[i] | bus.m_write[i];
            enable[i] = (lock_state == LOCK_FREE) || (owner == IDX_W'(i));
            if (owner == IDX_W'(i)) owner_req = req[i];
        end
    end

    assign granted       = arb_valid & ~reset;
    assign bus.mem_clken = 1'b1;

    // Route the granted master to memory; write wins over a simultaneous read.
    always_comb begin
        bus.mem_address    = '0;
        bus.mem_byteenable = '0;
        bus.mem_write      = 1'b0;
        bus.mem_writedata  = '0;
        bus.mem_chipselect = granted;
        bus.m_waitrequest  = '1;
        lock_bit           = 1'b0;
        accept_read        = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (grant[i] && !reset) begin
                bus.mem_address      = bus.m_address[i*ADDR_W +: ADDR_W];
                bus.mem_byteenable   = bus.m_byteenable[i*BE_W +: BE_W];
                bus.mem_write        = bus.m_write[i];
                bus.mem_writedata    = bus.m_writedata[i*DATA_W +: DATA_W];
                bus.m_waitrequest[i] = 1'b0;
                lock_bit             = bus.m_lock[i];
                accept_read          = bus.m_read[i] & ~bus.m_write[i];
            end
        end
    end

    // Read return: memory data passes straight through to the tagged master, others hold.
    always_comb begin
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            bus.m_readdatavalid[i] = rd_valid && (rd_id == IDX_W'(i));
            bus.m_readdata[i*DATA_W +: DATA_W] = bus.m_readdatavalid[i] ? bus.mem_readdata : rd_hold[i];
        end
    end

    // One-deep read pipe tracking which master owns the returning word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_id    <= '0;
            rd_hold  <= '0;
        end else begin
            rd_valid <= granted & accept_read;
            if (granted && accept_read) rd_id <= grant_idx;
            if (rd_valid) rd_hold[rd_id] <= bus.mem_readdata;
        end
    end

    // Lock owner FSM with idle timeout; a new locked transfer overrides any release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state   <= LOCK_FREE;
            owner        <= '0;
            idle_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            lock_timeout <= 1'b0;
            if (lock_state == LOCK_HELD) begin
                if (owner_req) begin
                    idle_cnt <= '0;
                    if (granted && !lock_bit) lock_state <= LOCK_FREE;
                end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 2)) begin
                    lock_state   <= LOCK_FREE;
                    lock_timeout <= 1'b1;
                    idle_cnt     <= '0;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end
            if (granted && lock_bit) begin
                lock_state <= LOCK_HELD;
                owner      <= grant_idx;
                idle_cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_soc_data_memory_arbiter.sv
// Directed bench for the data memory arbiter with a 1-cycle-latency memory model.
module tb_soc_data_memory_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic lock_timeout;
    int   passed = 0;
    int   fails  = 0;
    int   total  = 0;

    soc_data_memory_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(15), .DATA_W(32), .BE_W(4)) bus ();

    soc_data_memory_arbiter #(
        .NUM_MASTERS(2), .ADDR_W(15), .DATA_W(32), .BE_W(4), .LOCK_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    // Memory model: read data is a fixed function of address, one cycle after issue.
    always @(posedge clk) begin
        if (bus.mem_chipselect && !bus.mem_write)
            bus.mem_readdata <= 32'hC0DE_0000 | 32'(bus.mem_address);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.m_read       = '0;
        bus.m_write      = '0;
        bus.m_lock       = '0;
        bus.m_address    = '0;
        bus.m_byteenable = '0;
        bus.m_writedata  = '0;
    endtask

    task automatic m_rd(input int i, input logic [14:0] a, input logic lk);
        bus.m_read[i]           = 1'b1;
        bus.m_lock[i]           = lk;
        bus.m_address[i*15 +: 15] = a;
        bus.m_byteenable[i*4 +: 4] = 4'hF;
    endtask

    task automatic m_wr(input int i, input logic [14:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic lk);
        bus.m_write[i]             = 1'b1;
        bus.m_lock[i]              = lk;
        bus.m_address[i*15 +: 15]  = a;
        bus.m_writedata[i*32 +: 32] = d;
        bus.m_byteenable[i*4 +: 4] = be;
    endtask

    initial begin
        // Reset with both masters requesting: nothing may be granted.
        reset = 1'b1;
        idle();
        bus.m_read = 2'b11;
        #2;
        check("rst_wait",   64'(bus.m_waitrequest), 64'h3);
        check("rst_rvalid", 64'(bus.m_readdatavalid), 64'h0);
        check("rst_cs",     64'(bus.mem_chipselect), 64'h0);
        check("rst_lockto", 64'(lock_timeout), 64'h0);
        check("rst_clken",  64'(bus.mem_clken), 64'h1);
        @(negedge clk);
        reset = 1'b0;
        idle();

        // 1: single write from m0, accepted in the same cycle.
        @(negedge clk); idle(); m_wr(0, 15'h0010, 32'hDEAD_BEEF, 4'hF, 1'b0); #1;
        check("t1_wait",  64'(bus.m_waitrequest), 64'h2);
        check("t1_cs",    64'(bus.mem_chipselect), 64'h1);
        check("t1_we",    64'(bus.mem_write), 64'h1);
        check("t1_addr",  64'(bus.mem_address), 64'h10);
        check("t1_wdata", 64'(bus.mem_writedata), 64'hDEAD_BEEF);
        check("t1_be",    64'(bus.mem_byteenable), 64'hF);
        @(negedge clk); idle(); #1;
        check("t1_idle_cs", 64'(bus.mem_chipselect), 64'h0);
        check("t1_no_rdv",  64'(bus.m_readdatavalid), 64'h0);

        // 2: m1 alone, then both reading every cycle -> 0,1,0,1.
        @(negedge clk); idle(); m_rd(1, 15'h3, 1'b0); #1;
        check("t2a_wait", 64'(bus.m_waitrequest), 64'h1);
        check("t2a_addr", 64'(bus.mem_address), 64'h3);
        @(negedge clk); idle(); m_rd(0, 15'h1, 1'b0); m_rd(1, 15'h2, 1'b0); #1;
        check("t2b_wait", 64'(bus.m_waitrequest), 64'h2);
        check("t2b_rdv",  64'(bus.m_readdatavalid), 64'h2);
        check("t2b_rd1",  64'(bus.m_readdata[63:32]), 64'hC0DE_0003);
        @(negedge clk); #1;
        check("t2c_wait", 64'(bus.m_waitrequest), 64'h1);
        check("t2c_addr", 64'(bus.mem_address), 64'h2);
        check("t2c_rdv",  64'(bus.m_readdatavalid), 64'h1);
        check("t2c_rd0",  64'(bus.m_readdata[31:0]), 64'hC0DE_0001);
        @(negedge clk); #1;
        check("t2d_wait", 64'(bus.m_waitrequest), 64'h2);
        check("t2d_rdv",  64'(bus.m_readdatavalid), 64'h2);
        check("t2d_rd1",  64'(bus.m_readdata[63:32]), 64'hC0DE_0002);
        @(negedge clk); #1;
        check("t2e_wait", 64'(bus.m_waitrequest), 64'h1);
        check("t2e_rdv",  64'(bus.m_readdatavalid), 64'h1);
        @(negedge clk); idle(); #1;
        check("t2f_rdv",  64'(bus.m_readdatavalid), 64'h2);
        @(negedge clk); #1;
        check("t2g_rdv",  64'(bus.m_readdatavalid), 64'h0);
        check("t2g_hold0", 64'(bus.m_readdata[31:0]), 64'hC0DE_0001);
        check("t2g_hold1", 64'(bus.m_readdata[63:32]), 64'hC0DE_0002);

        // 3: m1 locks, m0 is blocked until m1's unlocking write.
        @(negedge clk); idle(); m_rd(1, 15'h5, 1'b1); #1;
        check("t3a_wait", 64'(bus.m_waitrequest), 64'h1);
        @(negedge clk); idle(); m_rd(0, 15'h6, 1'b0); m_rd(1, 15'h7, 1'b1); #1;
        check("t3b_wait", 64'(bus.m_waitrequest), 64'h1);
        check("t3b_rdv",  64'(bus.m_readdatavalid), 64'h2);
        @(negedge clk); idle(); m_rd(0, 15'h6, 1'b0); m_wr(1, 15'h0004, 32'h1234_5678, 4'hF, 1'b0); #1;
        check("t3c_wait", 64'(bus.m_waitrequest), 64'h1);
        check("t3c_we",   64'(bus.mem_write), 64'h1);
        check("t3c_addr", 64'(bus.mem_address), 64'h4);
        check("t3c_rd1",  64'(bus.m_readdata[63:32]), 64'hC0DE_0007);
        @(negedge clk); idle(); m_rd(0, 15'h6, 1'b0); #1;
        check("t3d_wait", 64'(bus.m_waitrequest), 64'h2);
        check("t3d_addr", 64'(bus.mem_address), 64'h6);
        @(negedge clk); idle(); #1;
        check("t3e_rdv",  64'(bus.m_readdatavalid), 64'h1);
        check("t3e_rd0",  64'(bus.m_readdata[31:0]), 64'hC0DE_0006);

        // 4: m0 locks then idles; m1 gets through only on the timeout cycle.
        @(negedge clk); idle(); m_rd(0, 15'h8, 1'b1); #1;
        check("t4_lock_wait", 64'(bus.m_waitrequest), 64'h2);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk); idle(); m_rd(1, 15'h9, 1'b0); #1;
            check($sformatf("t4_blocked_%0d", k), 64'({lock_timeout, bus.m_waitrequest}), 64'h3);
        end
        @(negedge clk); idle(); m_rd(1, 15'h9, 1'b0); #1;
        check("t4_timeout", 64'(lock_timeout), 64'h1);
        check("t4_wait",    64'(bus.m_waitrequest), 64'h1);
        check("t4_addr",    64'(bus.mem_address), 64'h9);
        @(negedge clk); idle(); #1;
        check("t4_pulse_end", 64'(lock_timeout), 64'h0);
        check("t4_rdv",       64'(bus.m_readdatavalid), 64'h2);
        check("t4_rd1",       64'(bus.m_readdata[63:32]), 64'hC0DE_0009);

        // 5: read and write together -> write only, no read return.
        @(negedge clk); idle(); m_rd(0, 15'h0020, 1'b0); m_wr(0, 15'h0020, 32'hCAFE_F00D, 4'h3, 1'b0); #1;
        check("t5_wait",  64'(bus.m_waitrequest), 64'h2);
        check("t5_we",    64'(bus.mem_write), 64'h1);
        check("t5_addr",  64'(bus.mem_address), 64'h20);
        check("t5_be",    64'(bus.mem_byteenable), 64'h3);
        check("t5_wdata", 64'(bus.mem_writedata), 64'hCAFE_F00D);
        @(negedge clk); idle(); #1;
        check("t5_no_rdv", 64'(bus.m_readdatavalid), 64'h0);

        // 6: reset right after a read accept drops the pending return.
        @(negedge clk); idle(); m_rd(0, 15'h0021, 1'b0); #1;
        check("t6_accept", 64'(bus.m_waitrequest), 64'h2);
        @(posedge clk); #1;
        reset = 1'b1;
        m_rd(1, 15'h0022, 1'b0);
        #1;
        check("t6_rst_rdv",  64'(bus.m_readdatavalid), 64'h0);
        check("t6_rst_wait", 64'(bus.m_waitrequest), 64'h3);
        check("t6_rst_cs",   64'(bus.mem_chipselect), 64'h0);
        @(posedge clk); #1;
        check("t6_rst_rdv2", 64'(bus.m_readdatavalid), 64'h0);
        @(negedge clk); reset = 1'b0; idle(); #1;
        check("t6_post_rdv", 64'(bus.m_readdatavalid), 64'h0);
        check("t6_post_lto", 64'(lock_timeout), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
